// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian words into instruction memory and holds the CPU in reset until loaded.
// Build option LOADER_CHECKSUM_EN adds a trailing checksum word that must match the sum of all written words.
//
// state | meaning
// IDLE  | CPU held in reset, waiting for start_i
// LOAD  | accepting stream bytes, writing one word per 4 bytes
// RUN   | image committed, CPU released
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int LEN_W       = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             cpu_rst_n_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  localparam logic [LEN_W-1:0] DEPTH_V = LEN_W'(DEPTH_WORDS);
  localparam logic [LEN_W-1:0] ONE_V   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [23:0]      part_q, part_d;
  logic             byte_ready_d, mem_we_d, cpu_rst_n_d, busy_d, done_d, err_d;
  logic [31:0]      mem_addr_d, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic             ck_phase_q, ck_phase_d;
  logic [31:0]      sum_q, sum_d;
`endif

  logic        accept, word_full, data_word, last_data;
  logic        start_take, len_zero, len_over, fin_ok, fin_bad;
  logic [31:0] full_word;

  assign accept     = byte_ready_o & byte_valid_i;
  assign word_full  = accept && (byte_cnt_q == 2'd3);
  assign full_word  = {byte_i, part_q};
  assign last_data  = (word_idx_q == len_q - ONE_V);
  assign start_take = start_i && (state_q != LOAD);
  assign len_zero   = (len_i == '0);
  assign len_over   = (len_i > DEPTH_V);

`ifdef LOADER_CHECKSUM_EN
  assign data_word = word_full && !ck_phase_q;
  assign fin_ok    = word_full && ck_phase_q && (full_word == sum_q);
  assign fin_bad   = word_full && ck_phase_q && (full_word != sum_q);
`else
  assign data_word = word_full;
  assign fin_ok    = word_full && last_data;
  assign fin_bad   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      word_idx_q   <= '0;
      len_q        <= '0;
      part_q       <= '0;
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cpu_rst_n_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      ck_phase_q   <= 1'b0;
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      len_q        <= len_d;
      part_q       <= part_d;
      byte_ready_o <= byte_ready_d;
      mem_we_o     <= mem_we_d;
      mem_addr_o   <= mem_addr_d;
      mem_wdata_o  <= mem_wdata_d;
      cpu_rst_n_o  <= cpu_rst_n_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      err_o        <= err_d;
`ifdef LOADER_CHECKSUM_EN
      ck_phase_q   <= ck_phase_d;
      sum_q        <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (start_i) begin
          if (len_over)      state_d = IDLE;
          else if (len_zero) state_d = RUN;
          else               state_d = LOAD;
        end
      end
      LOAD: begin
        if (fin_ok)       state_d = RUN;
        else if (fin_bad) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    word_idx_d  = word_idx_q;
    len_d       = len_q;
    part_d      = part_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    done_d      = 1'b0;
    err_d       = err_o;
`ifdef LOADER_CHECKSUM_EN
    ck_phase_d  = ck_phase_q;
    sum_d       = sum_q;
`endif

    if (start_take) begin
      if (len_over) begin
        err_d = 1'b1;
      end else begin
        err_d      = 1'b0;
        len_d      = len_i;
        byte_cnt_d = '0;
        word_idx_d = '0;
        part_d     = '0;
        done_d     = len_zero;
`ifdef LOADER_CHECKSUM_EN
        ck_phase_d = 1'b0;
        sum_d      = '0;
`endif
      end
    end

    if (accept) begin
      if (word_full) begin
        byte_cnt_d = '0;
        part_d     = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    part_d[7:0]   = byte_i;
          2'd1:    part_d[15:8]  = byte_i;
          default: part_d[23:16] = byte_i;
        endcase
      end
    end

    if (data_word) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = {{(30-LEN_W){1'b0}}, word_idx_q, 2'b00};
      mem_wdata_d = full_word;
      word_idx_d  = word_idx_q + ONE_V;
`ifdef LOADER_CHECKSUM_EN
      sum_d       = sum_q + full_word;
      if (last_data) ck_phase_d = 1'b1;
`endif
    end

    if (fin_ok)  done_d = 1'b1;
    if (fin_bad) err_d  = 1'b1;

    // Release the CPU only after a full cycle in RUN, so the last write has settled.
    cpu_rst_n_d  = (state_q == RUN) && !start_i;
    byte_ready_d = (state_d == LOAD);
    busy_d       = (state_d == LOAD);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes come from a byte-list-to-word model.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int LW    = 9;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic [LW-1:0]   len_i = '0;
  logic [7:0]      byte_i = '0;
  logic            byte_valid_i = 1'b0;
  logic            byte_ready_o, mem_we_o, cpu_rst_n_o, busy_o, done_o, err_o;
  logic [31:0]     mem_addr_o, mem_wdata_o;

  imem_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_rst_n_o(cpu_rst_n_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        wr_q[$];
  int         done_q[$];
  int         acc_cyc[$];
  logic [7:0] stim[$];
  int         rise_cyc = -1;
  int         ready_viol = 0;
  logic       cpu_prev = 1'b0;

  always @(negedge clk_i) begin
    wr_t w;
    if (mem_we_o) begin
      w.addr = mem_addr_o;
      w.data = mem_wdata_o;
      w.cyc  = cyc;
      wr_q.push_back(w);
    end
    if (done_o) done_q.push_back(cyc);
    if (cpu_rst_n_o && !cpu_prev) rise_cyc = cyc;
    if (busy_o != byte_ready_o) ready_viol++;
    cpu_prev = cpu_rst_n_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start(input int len);
    start_i = 1'b1;
    len_i   = LW'(len);
    tick();
    start_i = 1'b0;
  endtask

  // Send every byte in stim with a random idle gap before each; optionally toss in stray start pulses.
  task automatic send(input int gmin, input int gmax, input bit noise);
    foreach (stim[i]) begin
      int gap;
      int budget;
      gap = $urandom_range(gmax, gmin);
      budget = 20;
      repeat (gap) tick();
      byte_valid_i = 1'b1;
      byte_i       = stim[i];
      if (noise && ($urandom_range(2, 0) == 0)) begin
        start_i = 1'b1;
        len_i   = LW'($urandom_range(300, 0));
      end
      while (!byte_ready_o && budget > 0) begin
        tick();
        budget--;
      end
      if (!byte_ready_o) check("ready_timeout", {31'b0, byte_ready_o}, 32'd1);
      tick();
      acc_cyc.push_back(cyc);
      byte_valid_i = 1'b0;
      start_i      = 1'b0;
    end
  endtask

  task automatic run_load(input int len, input int gmin, input int gmax,
                          input bit noise, input bit bad_ck, input string name);
    logic [31:0] exp_w[$];
    logic [31:0] sum;
    logic [31:0] v;
    int          fin;
    bit          exp_ok;
    sum = '0;
    exp_ok = !bad_ck;
    for (int w = 0; w < len; w++) begin
      v = '0;
      for (int k = 0; k < 4; k++) v = v | (32'(stim[4*w+k]) << (8*k));
      exp_w.push_back(v);
      sum = sum + v;
    end
`ifdef LOADER_CHECKSUM_EN
    if (bad_ck) sum = sum + 32'd1;
    for (int k = 0; k < 4; k++) stim.push_back(8'(sum >> (8*k)));
`endif
    wr_q.delete();
    done_q.delete();
    acc_cyc.delete();
    rise_cyc   = -1;
    ready_viol = 0;
    pulse_start(len);
    check({name, "_cpu_held"}, {31'b0, cpu_rst_n_o}, 32'd0);
    check({name, "_busy"}, {31'b0, busy_o}, 32'd1);
    check({name, "_err_clr"}, {31'b0, err_o}, 32'd0);
    send(gmin, gmax, noise);
    repeat (3) tick();
    fin = acc_cyc[acc_cyc.size()-1];
    check({name, "_nwr"}, wr_q.size(), len);
    for (int i = 0; i < len && i < wr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), wr_q[i].addr, 32'(4*i));
      check($sformatf("%s_data%0d", name, i), wr_q[i].data, exp_w[i]);
      check($sformatf("%s_lat%0d", name, i), wr_q[i].cyc, acc_cyc[4*i+3]);
    end
    check({name, "_ready_vs_busy"}, ready_viol, 0);
    check({name, "_busy_end"}, {31'b0, busy_o}, 32'd0);
    if (exp_ok) begin
      check({name, "_ndone"}, done_q.size(), 1);
      if (done_q.size() > 0) check({name, "_done_cyc"}, done_q[0], fin);
      check({name, "_rise_cyc"}, rise_cyc, fin + 1);
      check({name, "_cpu_run"}, {31'b0, cpu_rst_n_o}, 32'd1);
      check({name, "_err"}, {31'b0, err_o}, 32'd0);
    end else begin
      check({name, "_ndone"}, done_q.size(), 0);
      check({name, "_err"}, {31'b0, err_o}, 32'd1);
      check({name, "_cpu_held_end"}, {31'b0, cpu_rst_n_o}, 32'd0);
      check({name, "_no_rise"}, rise_cyc, -1);
    end
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_ready"}, {31'b0, byte_ready_o}, 32'd0);
    check({name, "_we"}, {31'b0, mem_we_o}, 32'd0);
    check({name, "_addr"}, mem_addr_o, 32'd0);
    check({name, "_wdata"}, mem_wdata_o, 32'd0);
    check({name, "_cpu"}, {31'b0, cpu_rst_n_o}, 32'd0);
    check({name, "_busy"}, {31'b0, busy_o}, 32'd0);
    check({name, "_done"}, {31'b0, done_o}, 32'd0);
    check({name, "_err"}, {31'b0, err_o}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    repeat (3) tick();
    check_reset_outs("rst");
    rst_i = 1'b1;
    tick();

    // Bytes offered in IDLE are never taken.
    wr_q.delete();
    byte_valid_i = 1'b1;
    byte_i = 8'h5A;
    repeat (6) tick();
    byte_valid_i = 1'b0;
    check("idle_ready", {31'b0, byte_ready_o}, 32'd0);
    check("idle_nwr", wr_q.size(), 0);

    stim = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0, 1'b0, 1'b0, "basic");
    if (wr_q.size() == 2) begin
      check("basic_w0_const", wr_q[0].data, 32'h00500013);
      check("basic_w1_const", wr_q[1].data, 32'h00100093);
    end

    stim = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 3, 3, 1'b0, 1'b0, "stall");

    // Reload from RUN with stray start pulses during LOAD.
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'($urandom));
    run_load(3, 0, 2, 1'b1, 1'b0, "reload");

    wr_q.delete();
    pulse_start(257);
    check("len257_err", {31'b0, err_o}, 32'd1);
    check("len257_busy", {31'b0, busy_o}, 32'd0);
    check("len257_ready", {31'b0, byte_ready_o}, 32'd0);
    check("len257_cpu", {31'b0, cpu_rst_n_o}, 32'd0);
    byte_valid_i = 1'b1;
    repeat (5) tick();
    byte_valid_i = 1'b0;
    check("len257_nwr", wr_q.size(), 0);
    check("len257_still_idle", {31'b0, busy_o}, 32'd0);

    wr_q.delete();
    pulse_start(0);
    check("len0_done", {31'b0, done_o}, 32'd1);
    check("len0_err_clr", {31'b0, err_o}, 32'd0);
    check("len0_cpu_first", {31'b0, cpu_rst_n_o}, 32'd0);
    tick();
    check("len0_done_one", {31'b0, done_o}, 32'd0);
    check("len0_cpu", {31'b0, cpu_rst_n_o}, 32'd1);
    check("len0_nwr", wr_q.size(), 0);

    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    pulse_start(2);
    send(0, 1, 1'b0);
    rst_i = 1'b0;
    #1;
    check_reset_outs("midrst");
    tick();
    rst_i = 1'b1;
    tick();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(1, 0, 1, 1'b0, 1'b0, "after_rst");
    if (wr_q.size() == 1) check("after_rst_const", wr_q[0].data, 32'hDDCCBBAA);

    for (int t = 0; t < 5; t++) begin
      len = $urandom_range(8, 1);
      stim.delete();
      for (int i = 0; i < 4*len; i++) stim.push_back(8'($urandom));
      run_load(len, 0, 2, 1'b1, 1'b0, $sformatf("rnd%0d", t));
    end

    stim.delete();
    for (int i = 0; i < 4*DEPTH; i++) stim.push_back(8'($urandom));
    run_load(DEPTH, 0, 0, 1'b0, 1'b0, "full");
    if (wr_q.size() == DEPTH) check("full_last_addr", wr_q[DEPTH-1].addr, 32'h000003FC);

`ifdef LOADER_CHECKSUM_EN
    stim = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0, 1'b0, 1'b0, "ck_good");
    check("ck_good_word", {stim[11], stim[10], stim[9], stim[8]}, 32'h006000A6);
    stim = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 0, 0, 1'b0, 1'b1, "ck_bad");
    check("ck_bad_word", {stim[11], stim[10], stim[9], stim[8]}, 32'h006000A7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the CPU instruction fetch path: receives a program as a byte stream over a valid/ready handshake.
- Assembles bytes into 32-bit little-endian words and writes them into Instruction_Memory at word-aligned byte addresses starting at 0.
- Holds the CPU in reset through cpu_rst_n_o while loading, and releases it once the last word is committed.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words.
- LEN_W, 9, width of len_i; must satisfy 2^LEN_W > DEPTH_WORDS.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse that begins a load of len_i words.
- len_i  input  LEN_W  program length in words, sampled when start_i is accepted.
- byte_i  input  8  stream data byte.
- byte_valid_i  input  1  byte_i is valid.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- mem_we_o  output  1  instruction memory write strobe, one cycle per word.
- mem_addr_o  output  32  byte address of the write, always a multiple of 4.
- mem_wdata_o  output  32  assembled instruction word.
- cpu_rst_n_o  output  1  active-low reset to the CPU; 0 holds the CPU in reset.
- busy_o  output  1  high in LOAD state.
- done_o  output  1  one-cycle pulse when a load completes successfully.
- err_o  output  1  sticky error flag; cleared by the next accepted start_i.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, byte_ready_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, cpu_rst_n_o 0, busy_o 0, done_o 0, err_o 0. The byte counter, word counter and partial word all clear to 0.
- States are IDLE, LOAD and RUN.
- IDLE:
  - cpu_rst_n_o is 0.
  - start_i with 1 <= len_i <= DEPTH_WORDS: move to LOAD; latch len_i; clear counters and err_o.
  - start_i with len_i == 0: move to RUN; pulse done_o the next cycle.
  - start_i with len_i > DEPTH_WORDS: set err_o; stay in IDLE.
- LOAD:
  - byte_ready_o is 1 and busy_o is 1.
  - A byte transfers only when byte_valid_i and byte_ready_o are both 1.
  - Byte k of a word (k = 0..3) lands in bits [8k+7:8k].
  - When the 4th byte is accepted at edge N, the cycle after edge N has mem_we_o=1, mem_addr_o=4*word_idx and mem_wdata_o=the full word. word_idx then increments.
  - mem_we_o lasts exactly one cycle. mem_addr_o and mem_wdata_o hold their values until the next write.
  - byte_valid_i low inserts a stall; no timeout.
  - start_i in LOAD is ignored.
- Last word:
  - On acceptance of byte 4 of word len-1, the next cycle shows the final write with done_o=1. byte_ready_o drops to 0 in the same cycle.
  - The state becomes RUN. cpu_rst_n_o rises one cycle after the final write cycle, so memory is settled before the first fetch.
- RUN:
  - cpu_rst_n_o is 1 and byte_ready_o is 0.
  - start_i re-enters IDLE handling in the same cycle. cpu_rst_n_o returns to 0 at the next edge, then a reload proceeds under the same rules.
- Boundary conditions:
  - Word address wraps are impossible because len_i is bounded.
  - rst_i asserted mid-load discards the partial word and all counters. No write is issued for a partial word, and memory already written is not cleared.
  - Bytes presented in IDLE or RUN are not accepted, because byte_ready_o is 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - After the len data words, LOAD accepts 4 more bytes forming a little-endian checksum word. No memory write is issued for it.
  - The loader keeps a running sum mod 2^32 of all written words.
  - On match: done_o pulses and the state goes to RUN; cpu_rst_n_o rises the next cycle.
  - On mismatch: err_o is set, done_o stays 0, the state returns to IDLE, and cpu_rst_n_o stays 0.
  - done_o and the checksum verdict occur in the cycle after the 4th checksum byte is accepted.
- When undefined: there is no checksum phase, and done_o follows the final data write as described in Behaviour.

Test Plan:
- Basic load:
  - Stimulus: start_i with len_i=2, then bytes 13 00 50 00 93 00 10 00 with valid held high.
  - Required: writes addr 0x0 data 0x00500013, then addr 0x4 data 0x00100093, each one cycle after its 4th byte. done_o pulses with the second write; cpu_rst_n_o is 1 one cycle later.
- Stalled stream:
  - Stimulus: same bytes as Basic load, with byte_valid_i low for 3 cycles between every byte.
  - Required: identical writes; no extra mem_we_o pulses; byte_ready_o stays 1 throughout LOAD.
- Length errors:
  - Stimulus: start_i with len_i=257 at DEPTH_WORDS=256.
  - Required: err_o=1, state IDLE, byte_ready_o=0, cpu_rst_n_o=0.
  - Stimulus: start_i with len_i=0.
  - Required: done_o pulse; cpu_rst_n_o goes to 1 with no writes.
- Mid-load reset:
  - Stimulus: assert rst_i after 6 bytes of a 2-word load, then start again with len_i=1 and bytes AA BB CC DD.
  - Required: single write at addr 0x0 with data 0xDDCCBBAA; no stale bytes.
- Reload from RUN:
  - Stimulus: start_i while in RUN.
  - Required: cpu_rst_n_o falls at the next edge; the new load writes from addr 0x0; start_i pulses during LOAD are ignored.
- Checksum (with LOADER_CHECKSUM_EN):
  - Stimulus: len_i=2 with words 0x00500013 and 0x00100093, checksum 0x006000A6.
  - Required: done_o pulses and the CPU is released.
  - Stimulus: checksum 0x006000A7.
  - Required: err_o=1 and cpu_rst_n_o stays 0.
